// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, phase encoding and the default ID register contents.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;

  localparam logic [APB_DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB responder phase tracker: state register, programmable wait counter, Pready and abort.
module apb_slave_fsm
  import apb_pkg::*;
#(
  parameter int unsigned WaitStates = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psel_i,
  input  logic penable_i,
  output logic latch_o,
  output logic pready_o
);

  apb_state_e state_q, state_d;
  apb_state_e phase;
  logic [3:0] cnt_q, cnt_d;

  // state_q records the phase of the previous cycle; the current phase is resolved from it and
  // the live Psel/Penable so the access phase starts in the first Penable cycle.
  always_comb begin
    phase = StIdle;
    if (psel_i) begin
      if (!penable_i) begin
        phase = StSetup;
      end else if (state_q == StSetup || state_q == StAccess) begin
        phase = StAccess;
      end
    end

    pready_o = (phase == StAccess) && (cnt_q == 4'd0);
    latch_o  = (phase == StSetup);

    // A completed access always falls back to idle; a back-to-back setup is seen next cycle.
    state_d = pready_o ? StIdle : phase;

    cnt_d = cnt_q;
    if (phase == StSetup) begin
      cnt_d = 4'(WaitStates);
    end else if (phase == StAccess && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB register-file peripheral: read-only ID at index 0, read/write words above, with
// programmable wait states and Pslverr on decode misses, misaligned and ID writes.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        Hclk,
  input  logic        Hresetin,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic        latch;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [IdxW-1:0] idx;
  logic            hit;
  logic            err;

  apb_slave_fsm #(
    .WaitStates (WAIT_STATES)
  ) u_fsm (
    .clk_i     (Hclk),
    .rst_ni    (Hresetin),
    .psel_i    (Psel),
    .penable_i (Penable),
    .latch_o   (latch),
    .pready_o  (Pready)
  );

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    if (latch) begin
      addr_d  = Paddr;
      wdata_d = Pwdata;
      write_d = Pwrite;
    end
  end

  // Decode works only on the setup-phase snapshot; bus changes during access are ignored.
  always_comb begin
    idx = addr_q[IdxW+1:2];
    hit = (addr_q[31:IdxW+2] == BASE_ADDR[31:IdxW+2]);
    err = !hit || (addr_q[1:0] != 2'b00) || (write_q && idx == '0);
  end

  assign Pslverr = Pready && err;

  always_comb begin
    regs_d = regs_q;
    if (Pready && write_q && !err) begin
      regs_d[idx] = wdata_q;
    end
  end

  always_comb begin
    Prdata = 32'h0;
    if (Pready && !write_q && !err) begin
      Prdata = (idx == '0) ? ID_VALUE : regs_q[idx];
    end
  end

  always_ff @(posedge Hclk or negedge Hresetin) begin
    if (!Hresetin) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: a zero-wait and a three-wait instance share one bus.
module tb_apb_slave_regfile;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hresetin;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  logic        use_ws3;
  logic        cur_sel, cur_rdy, cur_err;
  logic [31:0] cur_rdata;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   acc_cnt = 0;

  always #5 hclk = ~hclk;

  apb_slave_regfile #(
    .WAIT_STATES (0)
  ) u_dut0 (
    .Hclk     (hclk),
    .Hresetin (hresetin),
    .Psel     (psel0),
    .Penable  (penable),
    .Pwrite   (pwrite),
    .Paddr    (paddr),
    .Pwdata   (pwdata),
    .Prdata   (prdata0),
    .Pready   (pready0),
    .Pslverr  (pslverr0)
  );

  apb_slave_regfile #(
    .WAIT_STATES (3)
  ) u_dut3 (
    .Hclk     (hclk),
    .Hresetin (hresetin),
    .Psel     (psel3),
    .Penable  (penable),
    .Pwrite   (pwrite),
    .Paddr    (paddr),
    .Pwdata   (pwdata),
    .Prdata   (prdata3),
    .Pready   (pready3),
    .Pslverr  (pslverr3)
  );

  assign cur_sel   = use_ws3 ? psel3    : psel0;
  assign cur_rdy   = use_ws3 ? pready3  : pready0;
  assign cur_err   = use_ws3 ? pslverr3 : pslverr0;
  assign cur_rdata = use_ws3 ? prdata3  : prdata0;

  // Monitor: pops one expectation per Pready and counts the access cycles preceding it.
  always @(negedge hclk) begin
    if (!hresetin) begin
      acc_cnt = 0;
    end else if (cur_sel && penable) begin
      if (cur_rdy) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pready: got Pready=1, required no transfer completion");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          vectors++;
          if (cur_rdata !== e.rdata || cur_err !== e.err || acc_cnt != e.waits) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h err=%b waits=%0d, required rdata=%h err=%b waits=%0d",
                     e.name, cur_rdata, cur_err, acc_cnt, e.rdata, e.err, e.waits);
          end
        end
        acc_cnt = 0;
      end else begin
        acc_cnt++;
        if (cur_err !== 1'b0 || cur_rdata !== 32'h0) begin
          miscompares++;
          $display("FAIL wait_outputs: got err=%b rdata=%h, required 0 and 0", cur_err, cur_rdata);
        end
      end
    end else begin
      acc_cnt = 0;
      if (cur_rdy !== 1'b0 || cur_err !== 1'b0 || cur_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL idle_outputs: got rdy=%b err=%b rdata=%h, required 0 0 0",
                 cur_rdy, cur_err, cur_rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic set_sel(input logic v);
    psel0 = use_ws3 ? 1'b0 : v;
    psel3 = use_ws3 ? v : 1'b0;
  endtask

  task automatic idle();
    set_sel(1'b0);
    penable = 1'b0;
    @(posedge hclk) #1;
  endtask

  // Issues one transfer and returns one cycle after the Pready edge with the bus still held,
  // so a following call starts its setup phase immediately.
  task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    exp_t e;
    bit   got;
    e.rdata = erd;
    e.err   = eerr;
    e.waits = use_ws3 ? 3 : 0;
    e.name  = name;
    exp_q.push_back(e);
    set_sel(1'b1);
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    @(posedge hclk) #1;
    penable = 1'b1;
    // The slave must act on the setup snapshot, not on these scrambled values.
    paddr   = 32'h8000_003C;
    pwrite  = ~wr;
    pwdata  = 32'h5A5A_A5A5;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      if (cur_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: got no Pready within 20 cycles, required Pready", name);
    end
    @(posedge hclk) #1;
  endtask

  initial begin
    use_ws3  = 1'b0;
    psel0    = 1'b0;
    psel3    = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 32'h0;
    pwdata   = 32'h0;
    hresetin = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_pready", {31'h0, pready0}, 32'h0);
    check("rst_pslverr", {31'h0, pslverr0}, 32'h0);
    check("rst_prdata", prdata0, 32'h0);
    hresetin = 1'b1;
    @(posedge hclk) #1;

    // Reset contents and the ID register.
    xfer("rd_id", 32'h8000_0000, 1'b0, 32'h0, 32'hA9B0_0001, 1'b0);
    idle();
    xfer("rd_r1_rst", 32'h8000_0004, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();

    // Zero-wait write and readback.
    xfer("wr_r2", 32'h8000_0008, 1'b1, 32'd45, 32'h0, 1'b0);
    idle();
    xfer("rd_r2", 32'h8000_0008, 1'b0, 32'h0, 32'd45, 1'b0);
    idle();

    // Three wait states.
    use_ws3 = 1'b1;
    xfer("ws3_rd_r3_pre", 32'h8000_000C, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    xfer("ws3_wr_r3", 32'h8000_000C, 1'b1, 32'd52, 32'h0, 1'b0);
    idle();
    xfer("ws3_rd_r3", 32'h8000_000C, 1'b0, 32'h0, 32'd52, 1'b0);
    idle();

    // Error responses.
    use_ws3 = 1'b0;
    xfer("wr_id_err", 32'h8000_0000, 1'b1, 32'd1, 32'h0, 1'b1);
    idle();
    xfer("rd_id_after", 32'h8000_0000, 1'b0, 32'h0, 32'hA9B0_0001, 1'b0);
    idle();
    xfer("rd_miss", 32'h8100_0000, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    xfer("rd_misalign", 32'h8000_0006, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    xfer("wr_miss", 32'h9000_0008, 1'b1, 32'd5, 32'h0, 1'b1);
    idle();
    xfer("rd_r2_kept", 32'h8000_0008, 1'b0, 32'h0, 32'd45, 1'b0);
    idle();

    // Back-to-back, no idle cycle between the two transfers.
    xfer("b2b_wr_r4", 32'h8000_0010, 1'b1, 32'd543, 32'h0, 1'b0);
    xfer("b2b_rd_r4", 32'h8000_0010, 1'b0, 32'h0, 32'd543, 1'b0);
    idle();
    use_ws3 = 1'b1;
    xfer("ws3_b2b_wr_r4", 32'h8000_0010, 1'b1, 32'd7, 32'h0, 1'b0);
    xfer("ws3_b2b_rd_r4", 32'h8000_0010, 1'b0, 32'h0, 32'd7, 1'b0);
    idle();

    // Abort in the second access cycle.
    set_sel(1'b1);
    penable = 1'b0;
    paddr   = 32'h8000_0014;
    pwrite  = 1'b1;
    pwdata  = 32'd99;
    @(posedge hclk) #1;
    penable = 1'b1;
    @(posedge hclk) #1;
    idle();
    repeat (3) @(posedge hclk);
    #1;
    xfer("ws3_rd_r5_abort", 32'h8000_0014, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();

    // Reset during an access with wait states pending.
    set_sel(1'b1);
    penable = 1'b0;
    paddr   = 32'h8000_0018;
    pwrite  = 1'b1;
    pwdata  = 32'd77;
    @(posedge hclk) #1;
    penable = 1'b1;
    @(posedge hclk) #1;
    hresetin = 1'b0;
    #1;
    check("midrst_pready", {31'h0, pready3}, 32'h0);
    check("midrst_pslverr", {31'h0, pslverr3}, 32'h0);
    check("midrst_prdata", prdata3, 32'h0);
    set_sel(1'b0);
    penable = 1'b0;
    @(posedge hclk) #1;
    hresetin = 1'b1;
    @(posedge hclk) #1;
    xfer("ws3_rd_r3_rst", 32'h8000_000C, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    xfer("ws3_rd_r4_rst", 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    xfer("ws3_rd_r6_rst", 32'h8000_0018, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    use_ws3 = 1'b0;
    xfer("rd_r2_rst", 32'h8000_0008, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    xfer("rd_r4_rst", 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();

    repeat (2) @(posedge hclk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB responder at the far end of the AHB-to-APB bridge. It is selected by one bit of the bridge's Pselx bus and exposes a bank of 32-bit word registers. The number of wait states is programmable through a parameter, and the block raises Pslverr on illegal accesses. It serves as the bridge's standard peripheral model and as a reusable control-register block.

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of 2, 2..64
WAIT_STATES, 0, extra ACCESS cycles before Pready; 0..15
BASE_ADDR, 32'h8000_0000, base of the decode window; must be aligned to NUM_REGS*4
ID_VALUE, 32'hA9B0_0001, read-only contents of register 0

Ports:
Hclk  input  1  clock; all logic is on the rising edge
Hresetin  input  1  asynchronous, active-low reset
Psel  input  1  slave select; one bit of the bridge's Pselx
Penable  input  1  APB access-phase strobe
Pwrite  input  1  1 = write, 0 = read
Paddr  input  32  byte address
Pwdata  input  32  write data
Prdata  output  32  read data; valid only while Pready=1 on a read
Pready  output  1  transfer-complete strobe
Pslverr  output  1  error response; valid only while Pready=1

Behaviour:
- Reset is asynchronous and active-low on Hresetin. On reset: state=IDLE, wait counter=0, Prdata=0, Pready=0, Pslverr=0, registers 1..NUM_REGS-1 = 0.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE -> SETUP when Psel=1 and Penable=0. Psel=1 with Penable=1 in IDLE is a protocol violation: ignore it and stay in IDLE.
- On entry to SETUP, latch Paddr, Pwrite and Pwdata, and load the wait counter with WAIT_STATES.
- SETUP -> ACCESS on the next edge, provided Psel=1 and Penable=1. If Psel=0, return to IDLE. If Psel=1 and Penable=0, remain in SETUP and re-latch the inputs.
- In ACCESS the counter decrements each cycle while it is nonzero.
- Pready is combinational: Pready = (state==ACCESS) && (counter==0) && Psel && Penable.
- Latency: Pready rises in access cycle WAIT_STATES+1. With WAIT_STATES=0 the transfer is zero-wait, i.e. setup plus one access cycle, which matches the bridge's fixed two-cycle timing.
- On the Pready cycle edge: if Psel=1 and Penable=0 (back-to-back transfer), go to SETUP and latch the new inputs; otherwise go to IDLE.
- If Psel or Penable drops during ACCESS before Pready: abort, go to IDLE, commit no write, and keep Pready=0.
- Address decode: hit when Paddr[31:2+log2(NUM_REGS)] equals the matching bits of BASE_ADDR. Index = Paddr[log2(NUM_REGS)+1:2].
- Error condition (err) is any of:
  - decode miss
  - Paddr[1:0] != 0
  - a write to index 0
- Pslverr = Pready && err. It is 0 in all other cycles.
- Write commit happens on the edge where Pready=1, Pwrite=1 and err=0: regs[index] <= latched Pwdata. An erroring write changes no register.
- Read data: Prdata = regs[index] (ID_VALUE for index 0) while Pready=1, Pwrite=0 and err=0. In all other cases Prdata = 32'h0, including on error.
- All address, write and data decisions use the values latched in SETUP. Changes on the bus during ACCESS are ignored.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and no partial write survives.

Decomposition:
- Shared package apb_pkg holds:
  - the state encoding typedef (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10)
  - APB_DATA_W=32 and APB_ADDR_W=32
  - the default ID_VALUE
- One sub-module is natural: apb_slave_fsm, containing the state register, wait counter and Pready/abort logic.
- The register array and decode stay in the top level.

Test Plan:
1. Reset then idle: hold Hresetin=0 for 2 cycles, release -> Pready=0, Pslverr=0, Prdata=0. Read 0x8000_0000 -> 0xA9B0_0001; read 0x8000_0004 -> 0.
2. Zero-wait write/read, WAIT_STATES=0: write 0x8000_0008 <- 32'd45 -> Pready high in the first ACCESS cycle. Read back -> Prdata=45 in the Pready cycle.
3. Wait states, WAIT_STATES=3: write 0x8000_000C <- 32'd52 -> Pready=0 for 3 ACCESS cycles and 1 in the 4th. The register is unchanged until the Pready edge.
4. Errors:
   - write 0x8000_0000 <- 1 -> Pslverr=1 on the Pready cycle; a subsequent read returns ID_VALUE
   - read 0x8100_0000 -> Pslverr=1, Prdata=0
   - read 0x8000_0006 -> Pslverr=1
5. Back-to-back: write 0x8000_0010 <- 32'd543, then immediately read the same address (SETUP right after the Pready cycle) -> the read returns 543 with no IDLE cycle in between.
6. Abort and reset mid-transfer, WAIT_STATES=3:
   - drop Psel in the 2nd ACCESS cycle of a write to 0x8000_0014 -> Pready never rises and the register stays 0
   - assert Hresetin=0 during ACCESS -> outputs go to 0 at once and all registers read 0 after release
